acc_dma_responder: RTL and testbench

//  Accelerator-side responder on the DMA acc_* port. Decodes acc_addr against a base window,

---
 rtl/acc_dma_responder_pkg.sv | 27 ++
 rtl/acc_dma_responder_if.sv | 33 +++
 rtl/acc_dma_responder_fifo.sv | 60 ++++++
 rtl/acc_dma_responder.sv | 156 +++++++++++++++
 tb/tb_acc_dma_responder.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_dma_responder_pkg.sv
// Shared definitions for the accelerator DMA responder.
// Holds the register offsets inside the 16-byte window and the frame FSM
// state encoding. It also holds a helper that packs the STATUS register.
package acc_dma_responder_pkg;

    // Word offsets (acc_addr[3:2]) inside the register window
    localparam logic [1:0] OFS_DATA   = 2'd0;
    localparam logic [1:0] OFS_LEN    = 2'd1;
    localparam logic [1:0] OFS_STATUS = 2'd2;
    localparam logic [1:0] OFS_RCV    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_DRAIN = 2'd2
    } acc_state_e;

    // STATUS layout: {err, state[1:0], full, empty, 11'b0, fifo_count[15:0]}
    function automatic logic [31:0] pack_status(input logic        err,
                                                input acc_state_e  st,
                                                input logic        full,
                                                input logic        empty,
                                                input logic [15:0] count);
        return {err, st, full, empty, 11'b0, count};
    endfunction

endpackage

// File: rtl/acc_dma_responder_if.sv
// Bus bundle for the accelerator responder.
// It carries the DMA-facing acc_* register and data port and the outbound
// valid/ready word stream toward the compute core.
//   slave  : the responder (acc_dma_responder)
//   master : the DMA engine and the stream consumer, seen together
interface acc_dma_responder_if #(
    parameter int DATA_W = 32
);
    logic [31:0]       acc_addr;
    logic              acc_write;
    logic              acc_read;
    logic [DATA_W-1:0] acc_data_in;
    logic              acc_ready;
    logic [DATA_W-1:0] acc_data_out;
    logic              acc_rvalid;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              frame_done;

    modport slave (
        input  acc_addr, acc_write, acc_read, acc_data_in, out_ready,
        output acc_ready, acc_data_out, acc_rvalid,
               out_valid, out_data, out_last, frame_done
    );

    modport master (
        output acc_addr, acc_write, acc_read, acc_data_in, out_ready,
        input  acc_ready, acc_data_out, acc_rvalid,
               out_valid, out_data, out_last, frame_done
    );
endinterface

// File: rtl/acc_dma_responder_fifo.sv
// acc_sync_fifo: a single-clock FIFO with an asynchronous active-high reset.
// Ports:
//   push/wdata   write a word when not full (a push at full is dropped)
//   pop/rdata    rdata shows the head word; pop advances when not empty
//   full/empty   flags derived from the registered occupancy count
//   count        occupancy, 0..DEPTH
module acc_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        // DEPTH is a power of two, so pointer wrap is a natural overflow
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end
endmodule

// File: rtl/acc_dma_responder.sv
// acc_dma_responder: accelerator-side responder on the DMA acc_* port.
// It decodes a 16-byte register window at BASE_ADDR and pushes DATA writes
// into a local FIFO. It frames the words toward the core as a valid/ready
// stream whose length is programmed through LEN. STATUS and RCV reads are
// answered one cycle after acc_read.
// Ports: clk, reset (async, active-high), bus (acc_dma_responder_if.slave).
//
// state | meaning
// IDLE  | no frame open; a non-zero LEN write opens one
// RECV  | accepting DATA beats until rcv reaches len
// DRAIN | all beats received; streaming out the rest, DATA writes dropped
module acc_dma_responder
    import acc_dma_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          DATA_W    = 32,
    parameter int          DEPTH     = 16,
    parameter int          LEN_W     = 16
) (
    input logic               clk,
    input logic               reset,
    acc_dma_responder_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    acc_state_e        state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d, rcv_q, rcv_d, sent_q, sent_d;
    logic              err_q, err_d;
    logic              frame_done_q, frame_done_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              hit, wr_data, wr_len;
    logic [1:0]        offset;
    logic [LEN_W-1:0]  new_len;
    logic              push, pop, full, empty, last_word;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] fifo_rdata;

    // The byte lane bits are not part of the decode
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.acc_addr[1:0];

    acc_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (bus.acc_data_in),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        hit       = (bus.acc_addr[31:4] == BASE_ADDR[31:4]);
        offset    = bus.acc_addr[3:2];
        wr_data   = hit && bus.acc_write && (offset == OFS_DATA);
        wr_len    = hit && bus.acc_write && (offset == OFS_LEN);
        new_len   = bus.acc_data_in[LEN_W-1:0];
        push      = wr_data && (state_q == ST_RECV) && !full;
        pop       = !empty && bus.out_ready;
        last_word = !empty && (sent_q == len_q - LEN_W'(1));

        state_d      = state_q;
        len_d        = len_q;
        rcv_d        = rcv_q;
        sent_d       = sent_q;
        err_d        = err_q;
        frame_done_d = 1'b0;

        if (pop) begin
            sent_d = sent_q + LEN_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (wr_data) begin
                    err_d = 1'b1;
                end
                if (wr_len && (new_len != '0)) begin
                    state_d = ST_RECV;
                    len_d   = new_len;
                    rcv_d   = '0;
                    sent_d  = '0;
                    err_d   = 1'b0;
                end
            end
            ST_RECV: begin
                if (wr_len) begin
                    err_d = 1'b1;
                end
                if (push) begin
                    rcv_d = rcv_q + LEN_W'(1);
                    if (rcv_d == len_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (wr_data || wr_len) begin
                    err_d = 1'b1;
                end
                // The final push always lands before DRAIN, so the last word
                // can only leave the FIFO here
                if (pop && last_word) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Reads use the pre-write state, so a same-cycle write is not visible
        rvalid_d = bus.acc_read;
        rdata_d  = '0;
        if (hit && bus.acc_read) begin
            case (offset)
                OFS_STATUS: rdata_d = DATA_W'(pack_status(err_q, state_q, full, empty, 16'(count)));
                OFS_RCV:    rdata_d = DATA_W'(rcv_q);
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            rcv_q        <= '0;
            sent_q       <= '0;
            err_q        <= 1'b0;
            frame_done_q <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            rcv_q        <= rcv_d;
            sent_q       <= sent_d;
            err_q        <= err_d;
            frame_done_q <= frame_done_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
        end
    end

    assign bus.acc_ready    = !full;
    assign bus.acc_data_out = rdata_q;
    assign bus.acc_rvalid   = rvalid_q;
    assign bus.out_valid    = !empty;
    assign bus.out_data     = fifo_rdata;
    assign bus.out_last     = last_word;
    assign bus.frame_done   = frame_done_q;
endmodule

// File: tb/tb_acc_dma_responder.sv
module tb_acc_dma_responder;
    localparam logic [31:0] A_DATA = 32'h8000_0000;
    localparam logic [31:0] A_LEN  = 32'h8000_0004;
    localparam logic [31:0] A_STAT = 32'h8000_0008;
    localparam logic [31:0] A_RCV  = 32'h8000_000C;
    localparam int          DEPTH  = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    acc_dma_responder_if #(.DATA_W(32)) bus ();

    acc_dma_responder #(
        .BASE_ADDR (32'h8000_0000),
        .DATA_W    (32),
        .DEPTH     (DEPTH),
        .LEN_W     (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: the FIFO is a queue and the frame is plain counters
    logic [31:0] m_q[$];
    logic [1:0]  m_st;          // 0 idle, 1 receiving, 2 draining
    int          m_len, m_rcv, m_sent;
    logic        m_err, m_rvalid, m_fd;
    logic [31:0] m_rdata;

    logic [31:0] obs_words[$];
    logic [31:0] obs_last[$];
    int          fd_count;
    logic        last_ready;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic        rd;
        logic [31:0] wdata;
        logic        exp_rvalid;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_st = 2'd0; m_len = 0; m_rcv = 0; m_sent = 0;
        m_err = 1'b0; m_rvalid = 1'b0; m_fd = 1'b0; m_rdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.acc_addr = '0; bus.acc_write = 1'b0; bus.acc_read = 1'b0;
        bus.acc_data_in = '0; bus.out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One bus cycle: drive, check combinational outputs, advance the model,
    // take the edge, check registered outputs
    task automatic cycle(input logic [31:0] a, input logic w, input logic r,
                         input logic [31:0] d, input logic ordy);
        logic       full, empty, hit, pop;
        logic [1:0] ofs, s0;
        bus.acc_addr = a; bus.acc_write = w; bus.acc_read = r;
        bus.acc_data_in = d; bus.out_ready = ordy;
        #1;
        full  = (m_q.size() == DEPTH);
        empty = (m_q.size() == 0);
        last_ready = bus.acc_ready;
        chk("acc_ready", 32'(bus.acc_ready), 32'(!full));
        chk("out_valid", 32'(bus.out_valid), 32'(!empty));
        if (!empty) begin
            chk("out_data", bus.out_data, m_q[0]);
            chk("out_last", 32'(bus.out_last), 32'(m_sent == m_len - 1));
        end
        if (bus.out_valid && ordy) begin
            obs_words.push_back(bus.out_data);
            if (bus.out_last) obs_last.push_back(bus.out_data);
        end

        hit = (a[31:4] == 28'h800_0000);
        ofs = a[3:2];
        s0  = m_st;
        pop = !empty && ordy;
        m_rvalid = r;
        m_rdata  = '0;
        if (r && hit && ofs == 2'd2) m_rdata = {m_err, s0, full, empty, 11'b0, 16'(m_q.size())};
        if (r && hit && ofs == 2'd3) m_rdata = 32'(m_rcv);
        m_fd = 1'b0;
        if (pop) begin
            void'(m_q.pop_front());
            m_sent++;
            if (s0 == 2'd2 && m_sent == m_len) begin
                m_st = 2'd0;
                m_fd = 1'b1;
            end
        end
        if (w && hit && ofs == 2'd0) begin
            if (s0 == 2'd1) begin
                if (!full) begin
                    m_q.push_back(d);
                    m_rcv++;
                    if (m_rcv == m_len) m_st = 2'd2;
                end
            end else begin
                m_err = 1'b1;
            end
        end
        if (w && hit && ofs == 2'd1) begin
            if (s0 == 2'd0) begin
                if (d[15:0] != 16'd0) begin
                    m_len = int'(d[15:0]); m_rcv = 0; m_sent = 0; m_err = 1'b0; m_st = 2'd1;
                end
            end else begin
                m_err = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        chk("acc_rvalid", 32'(bus.acc_rvalid), 32'(m_rvalid));
        if (m_rvalid) chk("acc_data_out", bus.acc_data_out, m_rdata);
        chk("frame_done", 32'(bus.frame_done), 32'(m_fd));
        if (bus.frame_done) fd_count++;
    endtask

    task automatic idle(input logic ordy);
        cycle(32'h0, 1'b0, 1'b0, 32'h0, ordy);
    endtask

    task automatic read_expect(input logic [31:0] a, input logic [31:0] exp, input string name);
        cycle(a, 1'b0, 1'b1, 32'h0, 1'b0);
        chk(name, bus.acc_data_out, exp);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (m_q.size() != 0 && n < 200) begin
            idle(1'b1);
            n++;
        end
        chk(name, 32'(m_q.size()), 32'd0);
        idle(1'b1);
    endtask

    initial begin
        int k, n, fd0;

        do_reset();
        chk("rst_acc_ready",  32'(bus.acc_ready),  32'd1);
        chk("rst_out_valid",  32'(bus.out_valid),  32'd0);
        chk("rst_out_last",   32'(bus.out_last),   32'd0);
        chk("rst_acc_rvalid", 32'(bus.acc_rvalid), 32'd0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
        chk("rst_data_out",   bus.acc_data_out,    32'd0);

        // Register decode and error flag, from reset, consumer stalled
        vecs[0]  = '{A_STAT,        1'b0, 1'b1, 32'h0,  1'b1, 32'h0800_0000};
        vecs[1]  = '{A_RCV,         1'b0, 1'b1, 32'h0,  1'b1, 32'h0};
        vecs[2]  = '{A_DATA,        1'b0, 1'b1, 32'h0,  1'b1, 32'h0};
        vecs[3]  = '{A_LEN,         1'b0, 1'b1, 32'h0,  1'b1, 32'h0};
        vecs[4]  = '{32'h9000_0008, 1'b0, 1'b1, 32'h0,  1'b1, 32'h0};
        vecs[5]  = '{32'h4000_0000, 1'b1, 1'b0, 32'h7,  1'b0, 32'h0};
        vecs[6]  = '{A_DATA,        1'b1, 1'b0, 32'h55, 1'b0, 32'h0};
        vecs[7]  = '{A_STAT,        1'b0, 1'b1, 32'h0,  1'b1, 32'h8800_0000};
        vecs[8]  = '{A_LEN,         1'b1, 1'b0, 32'h3,  1'b0, 32'h0};
        vecs[9]  = '{A_STAT,        1'b0, 1'b1, 32'h0,  1'b1, 32'h2800_0000};
        vecs[10] = '{A_DATA,        1'b1, 1'b0, 32'h11, 1'b0, 32'h0};
        vecs[11] = '{A_STAT,        1'b0, 1'b1, 32'h0,  1'b1, 32'h2000_0001};
        vecs[12] = '{A_RCV,         1'b0, 1'b1, 32'h0,  1'b1, 32'h1};
        vecs[13] = '{A_LEN,         1'b1, 1'b0, 32'h5,  1'b0, 32'h0};
        vecs[14] = '{A_STAT,        1'b0, 1'b1, 32'h0,  1'b1, 32'hA000_0001};
        for (int i = 0; i < 15; i++) begin
            cycle(vecs[i].addr, vecs[i].wr, vecs[i].rd, vecs[i].wdata, 1'b0);
            chk($sformatf("vec%0d_rvalid", i), 32'(bus.acc_rvalid), 32'(vecs[i].exp_rvalid));
            if (vecs[i].exp_rvalid) chk($sformatf("vec%0d_rdata", i), bus.acc_data_out, vecs[i].exp_rdata);
        end

        // Eight-word frame with the consumer always ready
        do_reset();
        obs_words.delete(); obs_last.delete(); fd_count = 0;
        cycle(A_LEN, 1'b1, 1'b0, 32'd8, 1'b1);
        for (int i = 0; i < 8; i++) cycle(A_DATA, 1'b1, 1'b0, 32'hAA + 32'(i), 1'b1);
        drain("f8_drain_timeout");
        chk("f8_words", 32'(obs_words.size()), 32'd8);
        for (int i = 0; i < obs_words.size() && i < 8; i++)
            chk($sformatf("f8_word%0d", i), obs_words[i], 32'hAA + 32'(i));
        chk("f8_last_count", 32'(obs_last.size()), 32'd1);
        if (obs_last.size() > 0) chk("f8_last_word", obs_last[0], 32'hB1);
        chk("f8_frame_done", 32'(fd_count), 32'd1);
        read_expect(A_STAT, 32'h0800_0000, "f8_status_idle");
        read_expect(A_RCV, 32'd8, "f8_rcv");

        // Twenty-word frame against a stalled consumer, with the DMA holding beats
        do_reset();
        obs_words.delete(); obs_last.delete(); fd_count = 0;
        cycle(A_LEN, 1'b1, 1'b0, 32'd20, 1'b0);
        k = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(A_DATA, 1'b1, 1'b0, 32'h100 + 32'(k), 1'b0);
            if (last_ready) k++;
        end
        chk("f20_accepted_stalled", 32'(k), 32'd16);
        chk("f20_ready_low", 32'(bus.acc_ready), 32'd0);
        read_expect(A_STAT, 32'h3000_0010, "f20_status_full");
        // Push against a full FIFO while a pop happens: not captured
        cycle(A_DATA, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1);
        chk("full_push_blocked", 32'(last_ready), 32'd0);
        read_expect(A_STAT, 32'h2000_000F, "full_pop_count15");
        n = 0;
        while (k < 20 && n < 50) begin
            cycle(A_DATA, 1'b1, 1'b0, 32'h100 + 32'(k), 1'b1);
            if (last_ready) k++;
            n++;
        end
        chk("f20_accepted_total", 32'(k), 32'd20);
        drain("f20_drain_timeout");
        chk("f20_words", 32'(obs_words.size()), 32'd20);
        for (int i = 0; i < obs_words.size() && i < 20; i++)
            chk($sformatf("f20_word%0d", i), obs_words[i], 32'h100 + 32'(i));
        chk("f20_frame_done", 32'(fd_count), 32'd1);

        // Reset in the middle of a frame, right after a read response
        do_reset();
        cycle(A_LEN, 1'b1, 1'b0, 32'd4, 1'b0);
        cycle(A_DATA, 1'b1, 1'b0, 32'h1, 1'b0);
        cycle(A_DATA, 1'b1, 1'b0, 32'h2, 1'b0);
        cycle(A_STAT, 1'b0, 1'b1, 32'h0, 1'b0);
        reset = 1'b1;
        #1;
        chk("midrst_rvalid",     32'(bus.acc_rvalid), 32'd0);
        chk("midrst_acc_ready",  32'(bus.acc_ready),  32'd1);
        chk("midrst_out_valid",  32'(bus.out_valid),  32'd0);
        chk("midrst_frame_done", 32'(bus.frame_done), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        read_expect(A_STAT, 32'h0800_0000, "midrst_status");
        fd0 = fd_count;
        cycle(A_LEN, 1'b1, 1'b0, 32'd2, 1'b1);
        cycle(A_DATA, 1'b1, 1'b0, 32'h77, 1'b1);
        cycle(A_DATA, 1'b1, 1'b0, 32'h78, 1'b1);
        drain("midrst_drain_timeout");
        chk("midrst_frame_done_after", 32'(fd_count - fd0), 32'd1);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int op;
            logic ordy, rd;
            op   = int'($urandom_range(0, 9));
            ordy = ($urandom_range(0, 3) != 0);
            rd   = ($urandom_range(0, 3) == 0);
            case (op)
                0, 1, 2, 3, 4: cycle(A_DATA, 1'b1, rd, $urandom, ordy);
                5:       cycle(A_LEN, 1'b1, rd, 32'($urandom_range(0, 30)), ordy);
                6:       cycle(A_STAT, 1'b0, 1'b1, 32'h0, ordy);
                7:       cycle(A_RCV, 1'b0, 1'b1, 32'h0, ordy);
                8:       cycle(32'h4000_0000 | 32'($urandom_range(0, 15)), 1'b1, rd, $urandom, ordy);
                default: idle(ordy);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
